// File: rtl/rtr_flags_tracker.sv
// rtr_flags_tracker
// Per-output-port, per-packet-class credit tracker. Keeps one credit counter
// for every (port, message class, resource class). Allocations consume a
// credit and credit returns from the downstream router restore one. Every
// counter is summarised as two registered flag bits, which the flag-extraction
// mux consumes.
//
// Ports
//   clk            sole clock; all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   alloc_valid    one credit is consumed this cycle
//   alloc_mc       one-hot message class of the allocation
//   alloc_op       one-hot output port of the allocation
//   alloc_orc      one-hot resource class of the allocation
//   cred_valid_op  per-port credit return strobe
//   cred_pc_op     per-port one-hot packet class of the returned credit
//   flags_op_opc   registered flags; entry e = (op*nmc + mc)*nrc + rc,
//                  bit 2e = credit_avail, bit 2e+1 = all_free
//   error          sticky protocol error (bad select, underflow, overflow)
//
// All vectors are numbered ascending, so index 0 is the MSB. This matches the
// numbering the flag mux uses.
module rtr_flags_tracker #(
    parameter int num_message_classes = 2,
    parameter int num_resource_classes = 2,
    parameter int num_ports = 5,
    parameter int num_credits = 4,
    localparam int num_packet_classes = num_message_classes * num_resource_classes,
    localparam int cred_width = $clog2(num_credits + 1)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        alloc_valid,
    input  logic [0:num_message_classes-1]              alloc_mc,
    input  logic [0:num_ports-1]                        alloc_op,
    input  logic [0:num_resource_classes-1]             alloc_orc,
    input  logic [0:num_ports-1]                        cred_valid_op,
    input  logic [0:num_ports*num_packet_classes-1]     cred_pc_op,
    output logic [0:num_ports*num_packet_classes*2-1]   flags_op_opc,
    output logic                                        error
);

    localparam int num_entries = num_ports * num_packet_classes;
    localparam logic [cred_width-1:0] full_cnt = cred_width'(num_credits);
    localparam logic [cred_width-1:0] one_cnt  = cred_width'(1);

    logic [cred_width-1:0]       cnt_q [num_entries];
    logic [cred_width-1:0]       cnt_d [num_entries];
    logic [num_entries-1:0]      dec_e;
    logic [num_entries-1:0]      inc_e;
    logic [0:num_entries*2-1]    flags_d;
    logic                        error_d;
    logic                        alloc_legal;
    logic [num_ports-1:0]        ret_legal;

    // Decode the allocation and the credit returns into per-entry strobes.
    always_comb begin
        dec_e       = '0;
        inc_e       = '0;
        ret_legal   = '0;
        alloc_legal = $onehot(alloc_mc) && $onehot(alloc_op) && $onehot(alloc_orc);
        for (int p = 0; p < num_ports; p++) begin
            ret_legal[p] = $onehot(cred_pc_op[p*num_packet_classes +: num_packet_classes]);
            for (int m = 0; m < num_message_classes; m++) begin
                for (int r = 0; r < num_resource_classes; r++) begin
                    dec_e[(p*num_message_classes + m)*num_resource_classes + r] =
                        alloc_valid && alloc_legal && alloc_op[p] && alloc_mc[m] && alloc_orc[r];
                    inc_e[(p*num_message_classes + m)*num_resource_classes + r] =
                        cred_valid_op[p] && ret_legal[p] &&
                        cred_pc_op[p*num_packet_classes + m*num_resource_classes + r];
                end
            end
        end
    end

    // Next-state counters, error and flags. The flags come from the next-state
    // count, so they change on the same edge as the counter.
    always_comb begin
        error_d = error;
        flags_d = '0;
        if (alloc_valid && !alloc_legal) begin
            error_d = 1'b1;
        end
        for (int p = 0; p < num_ports; p++) begin
            if (cred_valid_op[p] && !ret_legal[p]) begin
                error_d = 1'b1;
            end
        end
        for (int e = 0; e < num_entries; e++) begin
            cnt_d[e] = cnt_q[e];
            // A consume and a return on the same counter cancel out, even
            // when the counter is empty or full.
            if (dec_e[e] && !inc_e[e]) begin
                if (cnt_q[e] == '0) begin
                    error_d = 1'b1;
                end else begin
                    cnt_d[e] = cnt_q[e] - one_cnt;
                end
            end else if (inc_e[e] && !dec_e[e]) begin
                if (cnt_q[e] == full_cnt) begin
                    error_d = 1'b1;
                end else begin
                    cnt_d[e] = cnt_q[e] + one_cnt;
                end
            end
            flags_d[2*e]   = (cnt_d[e] != '0);
            flags_d[2*e+1] = (cnt_d[e] == full_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < num_entries; e++) begin
                cnt_q[e] <= full_cnt;
            end
            flags_op_opc <= '1;
            error        <= 1'b0;
        end else begin
            for (int e = 0; e < num_entries; e++) begin
                cnt_q[e] <= cnt_d[e];
            end
            flags_op_opc <= flags_d;
            error        <= error_d;
        end
    end

endmodule

// File: tb/tb_rtr_flags_tracker.sv
module tb_rtr_flags_tracker;

    localparam int NP    = 5;
    localparam int NPC   = 4;
    localparam int NE    = 20;
    localparam int W     = 40;
    localparam int NCRED = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            alloc_valid;
    logic [0:1]      alloc_mc;
    logic [0:NP-1]   alloc_op;
    logic [0:1]      alloc_orc;
    logic [0:NP-1]   cred_valid_op;
    logic [0:NP*NPC-1] cred_pc_op;
    logic [0:W-1]    flags_op_opc;
    logic            error;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt[NE];
    logic [0:W-1] all_ones;

    always #5 clk = ~clk;

    rtr_flags_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_mc     (alloc_mc),
        .alloc_op     (alloc_op),
        .alloc_orc    (alloc_orc),
        .cred_valid_op(cred_valid_op),
        .cred_pc_op   (cred_pc_op),
        .flags_op_opc (flags_op_opc),
        .error        (error)
    );

    function automatic logic [0:W-1] model_flags();
        logic [0:W-1] f;
        for (int e = 0; e < NE; e++) begin
            f[2*e]   = (exp_cnt[e] != 0);
            f[2*e+1] = (exp_cnt[e] == NCRED);
        end
        return f;
    endfunction

    task automatic idle_inputs();
        alloc_valid   = 1'b0;
        alloc_mc      = '0;
        alloc_op      = '0;
        alloc_orc     = '0;
        cred_valid_op = '0;
        cred_pc_op    = '0;
    endtask

    task automatic alloc(input int op, input int mc, input int rc);
        alloc_valid   = 1'b1;
        alloc_op      = '0;
        alloc_mc      = '0;
        alloc_orc     = '0;
        alloc_op[op]  = 1'b1;
        alloc_mc[mc]  = 1'b1;
        alloc_orc[rc] = 1'b1;
    endtask

    task automatic ret(input int port, input int pc);
        cred_valid_op[port]        = 1'b1;
        cred_pc_op[port*NPC + pc]  = 1'b1;
    endtask

    // inputs change 1ns after the rising edge; outputs are sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int e = 0; e < NE; e++) exp_cnt[e] = NCRED;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        for (int e = 0; e < NE; e++) exp_cnt[e] = NCRED;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (flags_op_opc !== all_ones) begin
            n_fail++;
            $display("FAIL reset_flags_held: got %h want %h", flags_op_opc, all_ones);
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_error_held: got %b want 0", error);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (flags_op_opc !== all_ones) begin
            n_fail++;
            $display("FAIL reset_flags_released: got %h want %h", flags_op_opc, all_ones);
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_error_released: got %b want 0", error);
        end
    endtask

    // entry 10 = op 2, mc 1, rc 0 -> avail bit 20, all_free bit 21
    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            alloc(2, 1, 0);
            step();
            idle_inputs();
            exp_cnt[10] = NCRED - i;
            n_checks++;
            if (flags_op_opc !== model_flags()) begin
                n_fail++;
                $display("FAIL drain_flags_%0d: got %h want %h", i, flags_op_opc, model_flags());
            end
            n_checks++;
            if (error !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_error_%0d: got %b want 0", i, error);
            end
            if (i == 1) begin
                n_checks++;
                if (flags_op_opc[21] !== 1'b0 || flags_op_opc[20] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drain_first_bits: got avail=%b free=%b want avail=1 free=0",
                             flags_op_opc[20], flags_op_opc[21]);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (flags_op_opc[20] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain_last_avail: got %b want 0", flags_op_opc[20]);
                end
            end
        end
    endtask

    task automatic test_underflow();
        alloc(2, 1, 0);
        step();
        idle_inputs();
        n_checks++;
        if (flags_op_opc !== model_flags()) begin
            n_fail++;
            $display("FAIL underflow_flags: got %h want %h", flags_op_opc, model_flags());
        end
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_error: got %b want 1", error);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (error !== 1'b1 || flags_op_opc !== model_flags()) begin
                n_fail++;
                $display("FAIL underflow_sticky_%0d: got err=%b flags=%h want err=1 flags=%h",
                         i, error, flags_op_opc, model_flags());
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(2, 1, 0);
            step();
        end
        idle_inputs();
        exp_cnt[10] = 0;
        // empty counter: consume and return cancel
        alloc(2, 1, 0);
        ret(2, 2);
        step();
        idle_inputs();
        n_checks++;
        if (flags_op_opc !== model_flags() || flags_op_opc[20] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty_flags: got %h want %h", flags_op_opc, model_flags());
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty_error: got %b want 0", error);
        end
        // full counter (entry 0): consume and return cancel
        alloc(0, 0, 0);
        ret(0, 0);
        step();
        idle_inputs();
        n_checks++;
        if (flags_op_opc[0] !== 1'b1 || flags_op_opc[1] !== 1'b1 || flags_op_opc !== model_flags()) begin
            n_fail++;
            $display("FAIL simul_full_flags: got %h want %h", flags_op_opc, model_flags());
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_full_error: got %b want 0", error);
        end
    endtask

    // pc 3 = mc 1, rc 1: port 0 -> entry 3 (bits 6,7), port 4 -> entry 19 (bits 38,39)
    task automatic test_multiport_overflow();
        apply_reset();
        alloc(0, 1, 1);
        step();
        alloc(4, 1, 1);
        step();
        idle_inputs();
        exp_cnt[3]  = 3;
        exp_cnt[19] = 3;
        n_checks++;
        if (flags_op_opc !== model_flags() || flags_op_opc[7] !== 1'b0 || flags_op_opc[39] !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_drained: got %h want %h", flags_op_opc, model_flags());
        end
        ret(0, 3);
        ret(4, 3);
        step();
        idle_inputs();
        exp_cnt[3]  = 4;
        exp_cnt[19] = 4;
        n_checks++;
        if (flags_op_opc !== all_ones) begin
            n_fail++;
            $display("FAIL multi_returned: got %h want %h", flags_op_opc, all_ones);
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_return_error: got %b want 0", error);
        end
        ret(0, 3);
        step();
        idle_inputs();
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_error: got %b want 1", error);
        end
        n_checks++;
        if (flags_op_opc !== all_ones) begin
            n_fail++;
            $display("FAIL overflow_flags: got %h want %h", flags_op_opc, all_ones);
        end
    endtask

    task automatic test_illegal_and_async_reset();
        apply_reset();
        alloc(2, 1, 0);
        step();
        idle_inputs();
        exp_cnt[10] = 3;
        n_checks++;
        if (flags_op_opc !== model_flags() || error !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_setup: got err=%b flags=%h want err=0 flags=%h",
                     error, flags_op_opc, model_flags());
        end
        alloc_valid = 1'b1;
        alloc_op    = 5'b00110;
        alloc_mc    = 2'b01;
        alloc_orc   = 2'b10;
        step();
        idle_inputs();
        n_checks++;
        if (flags_op_opc !== model_flags()) begin
            n_fail++;
            $display("FAIL illegal_flags: got %h want %h", flags_op_opc, model_flags());
        end
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_error: got %b want 1", error);
        end
        // assert reset mid-cycle, well away from either clock edge
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (flags_op_opc !== all_ones) begin
            n_fail++;
            $display("FAIL async_reset_flags: got %h want %h", flags_op_opc, all_ones);
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_error: got %b want 0", error);
        end
        reset = 1'b1;
        for (int e = 0; e < NE; e++) exp_cnt[e] = NCRED;
        step();
        n_checks++;
        if (flags_op_opc !== all_ones || error !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got err=%b flags=%h want err=0 flags=%h",
                     error, flags_op_opc, all_ones);
        end
    endtask

    initial begin
        all_ones = '1;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_drain();
        test_underflow();
        test_simultaneous();
        test_multiport_overflow();
        test_illegal_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
